// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared types and helpers for the UART TX/RX buffering stage.
//   rx_err_t   : per-character receive error flags {brk, fe, pe}
//   rxfiftl_e  : RX trigger-level select encoding
//   trig_level : maps a trigger select to an occupancy threshold
package uart_fifo_pkg;

  typedef struct packed {
    logic brk;
    logic fe;
    logic pe;
  } rx_err_t;

  typedef enum logic [1:0] {
    RXTL_ONE     = 2'b00,
    RXTL_QUARTER = 2'b01,
    RXTL_HALF    = 2'b10,
    RXTL_NEAR    = 2'b11
  } rxfiftl_e;

  function automatic int unsigned trig_level(rxfiftl_e sel, int unsigned depth);
    int unsigned lvl;
    case (sel)
      RXTL_ONE:     lvl = 1;
      RXTL_QUARTER: lvl = depth / 4;
      RXTL_HALF:    lvl = depth / 2;
      default:      lvl = depth - 2;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// uart_fifo_ctrl_if: bundle of the control, data and status signals between the
// APB register file / UART shift registers (master) and uart_fifo_ctrl (slave).
// Optional macro UART_FIFO_CTRL_TX_THRESH_EN adds txfiftl / tx_trig.
interface uart_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
);
  logic              fifoen;
  logic              txclr;
  logic              rxclr;
  logic [1:0]        rxfiftl;
  logic              thr_wr_en;
  logic [DATA_W-1:0] pwdata;
  logic              tsr_load;
  logic              rx_push;
  logic [DATA_W-1:0] rsr_data;
  logic [2:0]        rx_err;
  logic              rbr_rd_en;
  logic              lsr_rd;
  logic              char_tick;

  logic [DATA_W-1:0] tx_data;
  logic              tx_empty;
  logic              tx_full;
  logic [CNT_W-1:0]  tx_cnt;
  logic [DATA_W+2:0] rbr;
  logic              rx_empty;
  logic              rx_full;
  logic [CNT_W-1:0]  rx_cnt;
  logic              rx_trig;
  logic              rx_overrun;
  logic              rx_fifo_err;
  logic              rx_timeout;
`ifdef UART_FIFO_CTRL_TX_THRESH_EN
  logic [1:0]        txfiftl;
  logic              tx_trig;
`endif

  modport master (
`ifdef UART_FIFO_CTRL_TX_THRESH_EN
    output txfiftl, input tx_trig,
`endif
    output fifoen, txclr, rxclr, rxfiftl, thr_wr_en, pwdata, tsr_load,
           rx_push, rsr_data, rx_err, rbr_rd_en, lsr_rd, char_tick,
    input  tx_data, tx_empty, tx_full, tx_cnt, rbr, rx_empty, rx_full,
           rx_cnt, rx_trig, rx_overrun, rx_fifo_err, rx_timeout
  );

  modport slave (
`ifdef UART_FIFO_CTRL_TX_THRESH_EN
    input txfiftl, output tx_trig,
`endif
    input  fifoen, txclr, rxclr, rxfiftl, thr_wr_en, pwdata, tsr_load,
           rx_push, rsr_data, rx_err, rbr_rd_en, lsr_rd, char_tick,
    output tx_data, tx_empty, tx_full, tx_cnt, rbr, rx_empty, rx_full,
           rx_cnt, rx_trig, rx_overrun, rx_fifo_err, rx_timeout
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with run-time capacity (DEPTH or 1).
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clr             flush (wins over push/pop)
//   i_push, i_wdata   write request and data
//   i_pop             pop request
//   i_cap             current capacity; full means count == capacity
//   o_rdata           head entry, 0 while empty
//   o_empty, o_full   registered flags
//   o_cnt, o_cnt_nxt  registered occupancy and its next value
//   o_push_ok/o_pop_ok  the push/pop actually taken this cycle
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_pop,
  input  logic [CNT_W-1:0] i_cap,
  output logic [W-1:0]     o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_push_ok,
  output logic             o_pop_ok
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_empty;
  logic             r_full;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [CNT_W-1:0] w_cnt_nxt;

  // A push into a full FIFO is only taken when a pop frees the slot this cycle.
  assign w_pop_ok  = !i_clr && i_pop && !r_empty;
  assign w_push_ok = !i_clr && i_push && (!r_full || w_pop_ok);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
        2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (i_clr) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_cnt   <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == i_cap);
    end
  end

  // Storage needs no reset: the head is masked to 0 while empty.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata   = r_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty   = r_empty;
  assign o_full    = r_full;
  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_push_ok = w_push_ok;
  assign o_pop_ok  = w_pop_ok;
endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: TX/RX buffering between the APB register file and the UART
// shift registers. FIFO mode (fifoen=1) gives DEPTH entries per direction,
// otherwise a single holding register. Adds sticky RX overrun, error-in-FIFO,
// RX trigger level and RX character timeout.
// Ports:
//   i_pclk    system clock
//   i_preset  synchronous active-high reset
//   bus       uart_fifo_ctrl_if.slave (controls, data, status flags)
// Optional macro UART_FIFO_CTRL_TX_THRESH_EN: txfiftl input and registered
// tx_trig output (tx_cnt <= 0, DEPTH/4, DEPTH/2, 3*DEPTH/4).
module uart_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = $clog2(DEPTH) + 1,
  parameter int TO_CHARS = 4
) (
  input logic               i_pclk,
  input logic               i_preset,
  uart_fifo_ctrl_if.slave   bus
);
  localparam int TO_W = $clog2(TO_CHARS + 1);

  logic             r_fifoen_q;
  logic             w_mode_tgl;
  logic             w_txclr;
  logic             w_rxclr;
  logic [CNT_W-1:0] w_cap;
  logic             w_tx_push_ok;
  logic             w_tx_pop_ok;
  logic [CNT_W-1:0] w_tx_cnt_nxt;
  logic             w_rx_push_ok;
  logic             w_rx_pop_ok;
  logic [CNT_W-1:0] w_rx_cnt_nxt;
  rx_err_t          w_head_err;
  logic [CNT_W-1:0] w_rx_level;

  logic             r_overrun;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] w_err_cnt_nxt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [TO_W-1:0]  w_to_cnt_nxt;
  logic             r_rx_timeout;
  logic             r_rx_trig;

  // A change of fifoen behaves as a simultaneous txclr and rxclr.
  assign w_mode_tgl = bus.fifoen ^ r_fifoen_q;
  assign w_txclr    = bus.txclr | w_mode_tgl;
  assign w_rxclr    = bus.rxclr | w_mode_tgl;
  assign w_cap      = bus.fifoen ? CNT_W'(DEPTH) : CNT_W'(1);

  uart_sync_fifo #(.W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .i_clk     (i_pclk),
    .i_rst     (i_preset),
    .i_clr     (w_txclr),
    .i_push    (bus.thr_wr_en),
    .i_wdata   (bus.pwdata),
    .i_pop     (bus.tsr_load),
    .i_cap     (w_cap),
    .o_rdata   (bus.tx_data),
    .o_empty   (bus.tx_empty),
    .o_full    (bus.tx_full),
    .o_cnt     (bus.tx_cnt),
    .o_cnt_nxt (w_tx_cnt_nxt),
    .o_push_ok (w_tx_push_ok),
    .o_pop_ok  (w_tx_pop_ok)
  );

  uart_sync_fifo #(.W(DATA_W + 3), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
    .i_clk     (i_pclk),
    .i_rst     (i_preset),
    .i_clr     (w_rxclr),
    .i_push    (bus.rx_push),
    .i_wdata   ({bus.rx_err, bus.rsr_data}),
    .i_pop     (bus.rbr_rd_en),
    .i_cap     (w_cap),
    .o_rdata   (bus.rbr),
    .o_empty   (bus.rx_empty),
    .o_full    (bus.rx_full),
    .o_cnt     (bus.rx_cnt),
    .o_cnt_nxt (w_rx_cnt_nxt),
    .o_push_ok (w_rx_push_ok),
    .o_pop_ok  (w_rx_pop_ok)
  );

  assign w_head_err = rx_err_t'(bus.rbr[DATA_W+2:DATA_W]);
  assign w_rx_level = bus.fifoen ? CNT_W'(trig_level(rxfiftl_e'(bus.rxfiftl), DEPTH))
                                 : CNT_W'(1);

  // Counts stored entries that carry any error bit.
  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (w_rxclr) begin
      w_err_cnt_nxt = '0;
    end else begin
      if (w_rx_push_ok && (bus.rx_err != 3'b000)) w_err_cnt_nxt = w_err_cnt_nxt + CNT_W'(1);
      if (w_rx_pop_ok && (w_head_err != '0))      w_err_cnt_nxt = w_err_cnt_nxt - CNT_W'(1);
    end
  end

  // Idle character counter; only meaningful while FIFO mode holds data.
  always_comb begin
    w_to_cnt_nxt = r_to_cnt;
    if (w_rxclr || bus.rx_push || bus.rbr_rd_en || !bus.fifoen || bus.rx_empty) begin
      w_to_cnt_nxt = '0;
    end else if (bus.char_tick && (r_to_cnt != TO_W'(TO_CHARS))) begin
      w_to_cnt_nxt = r_to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_fifoen_q   <= bus.fifoen;
      r_overrun    <= 1'b0;
      r_err_cnt    <= '0;
      r_to_cnt     <= '0;
      r_rx_timeout <= 1'b0;
      r_rx_trig    <= 1'b0;
    end else begin
      r_fifoen_q <= bus.fifoen;
      // A dropped push (not one discarded by a clear) outranks lsr_rd.
      if (bus.rx_push && !w_rxclr && !w_rx_push_ok) r_overrun <= 1'b1;
      else if (bus.lsr_rd)                          r_overrun <= 1'b0;
      r_err_cnt    <= w_err_cnt_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      r_rx_timeout <= (w_to_cnt_nxt == TO_W'(TO_CHARS));
      r_rx_trig    <= (w_rx_cnt_nxt >= w_rx_level);
    end
  end

  assign bus.rx_overrun  = r_overrun;
  assign bus.rx_fifo_err = (r_err_cnt != '0);
  assign bus.rx_timeout  = r_rx_timeout;
  assign bus.rx_trig     = r_rx_trig;

`ifdef UART_FIFO_CTRL_TX_THRESH_EN
  logic [CNT_W-1:0] w_tx_level;
  logic             r_tx_trig;

  always_comb begin
    case (bus.txfiftl)
      2'b00:   w_tx_level = '0;
      2'b01:   w_tx_level = CNT_W'(DEPTH / 4);
      2'b10:   w_tx_level = CNT_W'(DEPTH / 2);
      default: w_tx_level = CNT_W'((3 * DEPTH) / 4);
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (i_preset) r_tx_trig <= 1'b0;
    else          r_tx_trig <= (w_tx_cnt_nxt <= w_tx_level);
  end

  assign bus.tx_trig = r_tx_trig;
`else
  logic w_unused;
  assign w_unused = ^{w_tx_cnt_nxt, w_tx_push_ok, w_tx_pop_ok};
`endif
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed scenarios followed by randomized traffic, all
// checked every cycle against a queue-based model of the buffering stage.
module tb_uart_fifo_ctrl;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int TO_CHARS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_fifo_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  uart_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TO_CHARS(TO_CHARS)) u_dut (
    .i_pclk   (clk),
    .i_preset (rst),
    .bus      (bus.slave)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model state
  logic [DATA_W-1:0] tx_q[$];
  logic [DATA_W+2:0] rx_q[$];
  bit m_ov, m_trig, m_txtrig, m_fifoen_prev;
  int m_to, m_cap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v)
      $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp_v);
    else
      n_pass++;
  endtask

  task automatic set_idle();
    bus.thr_wr_en = 0; bus.tsr_load = 0; bus.rx_push = 0; bus.rbr_rd_en = 0;
    bus.lsr_rd = 0; bus.char_tick = 0; bus.txclr = 0; bus.rxclr = 0;
    bus.rx_err = 3'b000;
  endtask

  task automatic model_update();
    bit tgl, txc, rxc, tx_pop, rx_pop, pre_rx_empty, ov_set;
    int lvl;
    if (rst) begin
      tx_q.delete(); rx_q.delete();
      m_ov = 0; m_to = 0; m_trig = 0; m_txtrig = 0;
      m_fifoen_prev = bus.fifoen;
      m_cap = bus.fifoen ? DEPTH : 1;
      return;
    end
    tgl = (bus.fifoen != m_fifoen_prev);
    m_fifoen_prev = bus.fifoen;
    m_cap = bus.fifoen ? DEPTH : 1;
    txc = bus.txclr || tgl;
    rxc = bus.rxclr || tgl;
    pre_rx_empty = (rx_q.size() == 0);
    ov_set = 0;

    if (txc) tx_q.delete();
    else begin
      tx_pop = bus.tsr_load && (tx_q.size() > 0);
      if (bus.thr_wr_en && (tx_q.size() < m_cap || tx_pop)) tx_q.push_back(bus.pwdata);
      if (tx_pop) void'(tx_q.pop_front());
    end

    if (rxc) rx_q.delete();
    else begin
      rx_pop = bus.rbr_rd_en && (rx_q.size() > 0);
      if (bus.rx_push) begin
        if (rx_q.size() < m_cap || rx_pop) rx_q.push_back({bus.rx_err, bus.rsr_data});
        else ov_set = 1;
      end
      if (rx_pop) void'(rx_q.pop_front());
    end
    if (bus.lsr_rd) m_ov = 0;
    if (ov_set)     m_ov = 1;

    if (rxc || bus.rx_push || bus.rbr_rd_en || !bus.fifoen || pre_rx_empty) m_to = 0;
    else if (bus.char_tick && m_to < TO_CHARS) m_to++;

    if (!bus.fifoen) lvl = 1;
    else case (bus.rxfiftl)
      2'b00:   lvl = 1;
      2'b01:   lvl = DEPTH / 4;
      2'b10:   lvl = DEPTH / 2;
      default: lvl = DEPTH - 2;
    endcase
    m_trig = (rx_q.size() >= lvl);
`ifdef UART_FIFO_CTRL_TX_THRESH_EN
    m_txtrig = (tx_q.size() <= (int'(bus.txfiftl) * DEPTH) / 4);
`endif
  endtask

  task automatic compare();
    int nerr = 0;
    foreach (rx_q[i]) if (rx_q[i][DATA_W+2:DATA_W] != 3'b000) nerr++;
    chk("tx_cnt",      bus.tx_cnt,      tx_q.size());
    chk("tx_empty",    bus.tx_empty,    tx_q.size() == 0);
    chk("tx_full",     bus.tx_full,     tx_q.size() == m_cap);
    chk("tx_data",     bus.tx_data,     tx_q.size() ? tx_q[0] : 0);
    chk("rx_cnt",      bus.rx_cnt,      rx_q.size());
    chk("rx_empty",    bus.rx_empty,    rx_q.size() == 0);
    chk("rx_full",     bus.rx_full,     rx_q.size() == m_cap);
    chk("rbr",         bus.rbr,         rx_q.size() ? rx_q[0] : 0);
    chk("rx_trig",     bus.rx_trig,     m_trig);
    chk("rx_overrun",  bus.rx_overrun,  m_ov);
    chk("rx_fifo_err", bus.rx_fifo_err, nerr != 0);
    chk("rx_timeout",  bus.rx_timeout,  m_to == TO_CHARS);
`ifdef UART_FIFO_CTRL_TX_THRESH_EN
    chk("tx_trig",     bus.tx_trig,     m_txtrig);
`endif
  endtask

  // Apply current inputs for one clock, then check outputs mid-cycle.
  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare();
  endtask

  initial begin
    int p_push, p_pop;
    int pct[5] = '{0, 5, 30, 60, 90};
    rst = 1;
    bus.fifoen = 1; bus.rxfiftl = 2'b00; bus.pwdata = '0; bus.rsr_data = '0;
`ifdef UART_FIFO_CTRL_TX_THRESH_EN
    bus.txfiftl = 2'b00;
`endif
    set_idle();
    @(negedge clk);
    step();
    chk("rst_tx_empty", bus.tx_empty, 1);
    chk("rst_rbr", bus.rbr, 0);
    rst = 0;

    // TX fill, drop on full, in-order drain
    for (int i = 0; i < 16; i++) begin
      bus.thr_wr_en = 1; bus.pwdata = 8'(i); step();
    end
    chk("plan_tx_full", bus.tx_full, 1);
    chk("plan_tx_cnt16", bus.tx_cnt, 16);
    bus.pwdata = 8'hAA; step();
    chk("plan_tx_drop", bus.tx_cnt, 16);
    set_idle();
    for (int i = 0; i < 16; i++) begin
      chk("plan_tx_order", bus.tx_data, i);
      bus.tsr_load = 1; step();
    end
    chk("plan_tx_drained", bus.tx_empty, 1);

    // RX overrun and lsr_rd
    set_idle();
    for (int i = 0; i < 16; i++) begin
      bus.rx_push = 1; bus.rsr_data = 8'($urandom); step();
    end
    bus.rsr_data = 8'h55; step();
    chk("plan_ovr_set", bus.rx_overrun, 1);
    chk("plan_ovr_cnt", bus.rx_cnt, 16);
    set_idle(); bus.lsr_rd = 1; step();
    chk("plan_ovr_clr", bus.rx_overrun, 0);
    set_idle(); bus.rxclr = 1; step();

    // Trigger at half depth
    set_idle(); bus.rxfiftl = 2'b10;
    for (int i = 0; i < 7; i++) begin
      bus.rx_push = 1; bus.rsr_data = 8'(i); step();
    end
    chk("plan_trig7", bus.rx_trig, 0);
    step();
    chk("plan_trig8", bus.rx_trig, 1);
    set_idle(); bus.rbr_rd_en = 1; step();
    chk("plan_trig_pop", bus.rx_trig, 0);
    set_idle(); bus.rxclr = 1; step();

    // Error-in-FIFO
    set_idle(); bus.rx_push = 1; bus.rsr_data = 8'h11; bus.rx_err = 3'b010; step();
    bus.rx_err = 3'b000;
    for (int i = 0; i < 3; i++) begin
      bus.rsr_data = 8'(8'h20 + i); step();
    end
    chk("plan_err_set", bus.rx_fifo_err, 1);
    set_idle(); bus.rbr_rd_en = 1; step();
    chk("plan_err_clr", bus.rx_fifo_err, 0);
    set_idle(); bus.rxclr = 1; step();

    // Character timeout
    set_idle();
    for (int i = 0; i < 2; i++) begin
      bus.rx_push = 1; bus.rsr_data = 8'(8'h40 + i); step();
    end
    set_idle();
    for (int i = 0; i < 4; i++) begin
      bus.char_tick = 1; step();
    end
    chk("plan_to_set", bus.rx_timeout, 1);
    set_idle(); bus.rbr_rd_en = 1; step();
    chk("plan_to_pop", bus.rx_timeout, 0);
    set_idle();
    for (int i = 0; i < 3; i++) begin
      bus.char_tick = 1; step();
    end
    chk("plan_to_restart", bus.rx_timeout, 0);
    step();
    chk("plan_to_again", bus.rx_timeout, 1);

    // Single holding register mode
    set_idle(); bus.fifoen = 0; step();
    bus.rx_push = 1; bus.rsr_data = 8'h3C; step();
    chk("plan_nf_full", bus.rx_full, 1);
    chk("plan_nf_rbr", bus.rbr, 11'h03C);
    bus.rsr_data = 8'h77; step();
    chk("plan_nf_ovr", bus.rx_overrun, 1);
    set_idle(); bus.fifoen = 1; step();
    chk("plan_nf_flush", bus.rx_empty, 1);
    bus.lsr_rd = 1; step();

    // Randomized traffic with phase-varying push/pop pressure
    p_push = 50; p_pop = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) begin
        p_push = pct[$urandom_range(0, 4)];
        p_pop  = pct[$urandom_range(0, 4)];
      end
      if (c % 50 == 0) bus.rxfiftl = 2'($urandom);
`ifdef UART_FIFO_CTRL_TX_THRESH_EN
      if (c % 50 == 0) bus.txfiftl = 2'($urandom);
`endif
      if ($urandom_range(0, 299) == 0) bus.fifoen = ~bus.fifoen;
      rst           = ($urandom_range(0, 999) == 0);
      bus.thr_wr_en = ($urandom_range(0, 99) < p_push);
      bus.pwdata    = 8'($urandom);
      bus.tsr_load  = ($urandom_range(0, 99) < p_pop);
      bus.rx_push   = ($urandom_range(0, 99) < p_push);
      bus.rsr_data  = 8'($urandom);
      bus.rx_err    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      bus.rbr_rd_en = ($urandom_range(0, 99) < p_pop);
      bus.txclr     = ($urandom_range(0, 99) == 0);
      bus.rxclr     = ($urandom_range(0, 99) == 0);
      bus.lsr_rd    = ($urandom_range(0, 9) == 0);
      bus.char_tick = ($urandom_range(0, 9) < 3);
      step();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Parametrised TX/RX buffering stage between the APB register file and the UART shift registers. It replaces the fixed 16-deep, 8-bit holding logic with configurable width and depth. It adds a registered overrun flag, an error-in-FIFO indicator, a positive receive trigger and a receive character-timeout counter. In non-FIFO mode each direction reduces to a single holding register with identical flag semantics.

Parameters:
DATA_W, 8, character width in bits (5..9)
DEPTH, 16, entries per FIFO; power of two, minimum 4
CNT_W, $clog2(DEPTH)+1, width of the occupancy counts
TO_CHARS, 4, idle character times before rx_timeout asserts

Ports:
pclk  in  1  system clock
preset  in  1  reset, synchronous, active-high
fifoen  in  1  1 = FIFO mode, 0 = single holding register
txclr  in  1  one-cycle TX flush
rxclr  in  1  one-cycle RX flush
rxfiftl  in  2  RX trigger select
thr_wr_en  in  1  push pwdata into TX
pwdata  in  DATA_W  TX write data
tsr_load  in  1  pop TX head into shift register
rx_push  in  1  character received
rsr_data  in  DATA_W  received character
rx_err  in  3  {break, frame, parity} for rsr_data
rbr_rd_en  in  1  pop RX head
lsr_rd  in  1  line-status read; clears sticky flags
char_tick  in  1  one pulse per character time
tx_data  out  DATA_W  TX head
tx_empty  out  1  TX has no entries
tx_full  out  1  TX at capacity
tx_cnt  out  CNT_W  TX occupancy
rbr  out  DATA_W+3  {err[2:0], data} of RX head
rx_empty  out  1  RX has no entries
rx_full  out  1  RX at capacity
rx_cnt  out  CNT_W  RX occupancy
rx_trig  out  1  rx_cnt >= trigger level
rx_overrun  out  1  sticky: push dropped while RX full
rx_fifo_err  out  1  at least one stored entry has nonzero err
rx_timeout  out  1  character timeout pending

Behaviour:
- Reset, synchronous and active-high on preset at a pclk edge: both FIFOs empty; counts 0; tx_empty=rx_empty=1; full=0; tx_data=0; rbr=0; rx_trig=0; rx_overrun=0; rx_fifo_err=0; rx_timeout=0; timeout counter 0. Reset overrides every other input in the same cycle.
- Capacity: DEPTH when fifoen=1, 1 when fifoen=0. Full means cnt == capacity.
- Flag timing: push and pop update storage and counts on the clock edge. Flags and counts are registered and valid the following cycle. The head output is combinational from storage, so there is zero read latency after non-empty.
- Priority per FIFO: clear > push/pop.
  - Clear empties the FIFO.
  - A push in the same cycle as a clear is discarded.
  - rxclr also clears rx_fifo_err, rx_timeout and the timeout counter. rx_overrun is unaffected.
- Push when full:
  - Push and pop in the same cycle: both execute and cnt is unchanged.
  - Push without pop: the data is dropped. On RX, rx_overrun sets. On TX, the push is silently ignored.
- Pop when empty: ignored. cnt never underflows.
- Simultaneous push and pop when empty: the push executes and the pop is ignored.
- Pointers wrap modulo DEPTH.
- fifoen change: both FIFOs are flushed in the cycle fifoen toggles, as an implicit txclr and rxclr.
- Trigger levels, with rxfiftl=00/01/10/11: 1, DEPTH/4, DEPTH/2, DEPTH-2. With fifoen=0 the level is 1.
- rx_overrun: set as above; cleared by lsr_rd. If set and clear coincide, set wins.
- rx_fifo_err: an internal error counter increments on a push with rx_err!=0 and decrements on a pop of an entry with err!=0. rx_fifo_err = (counter != 0).
- Timeout counter: runs only in FIFO mode with RX non-empty.
  - Resets to 0 on rx_push, rbr_rd_en or rxclr.
  - Otherwise increments on char_tick and saturates at TO_CHARS.
  - rx_timeout = (counter == TO_CHARS), registered. It deasserts the cycle after a pop, push or clear.

Optional Feature:
UART_FIFO_CTRL_TX_THRESH_EN
- Defined: adds input txfiftl[1:0] and output tx_trig. tx_trig = tx_cnt <= level, with levels 0, DEPTH/4, DEPTH/2, 3*DEPTH/4. The output is registered and is 0 at reset.
- Undefined: the port and logic are absent. Consumers use tx_empty only.

Decomposition:
- Package uart_fifo_pkg holds:
  - typedef rx_err_t (packed struct: brk, fe, pe);
  - trigger-select enum rxfiftl_e;
  - function trig_level(sel, depth).
- Sub-module uart_sync_fifo #(W, DEPTH): storage, pointers, count, clear, full/empty, and a capacity input for single-entry mode. It is instantiated once for TX and once for RX.
- Overrun, error count, trigger and timeout logic stay in the top.

Test Plan:
- Reset, then 16 TX pushes 0x00..0x0F with fifoen=1 → tx_full=1, tx_cnt=16. A 17th push of 0xAA is dropped. 16 tsr_load pops return 0x00..0x0F in order.
- RX filled to 16, then rx_push of 0x55 without a read → rx_overrun=1, rx_cnt=16. lsr_rd clears rx_overrun; data remains intact.
- rxfiftl=10, push 7 characters → rx_trig=0. The 8th push gives rx_trig=1 one cycle later. One pop returns rx_trig to 0.
- Push one character with rx_err=3'b010, then 3 clean characters → rx_fifo_err=1. Popping the error entry drops rx_fifo_err to 0.
- 2 characters in RX, then 4 char_tick pulses with no activity → rx_timeout=1. rbr_rd_en deasserts it, and the count restarts.
- fifoen=0: push 0x3C → rx_full=1 and rbr=0x03C. A second push with no read sets rx_overrun. Toggling fifoen flushes to rx_empty=1.
